// File: rtl/inst_encoder.sv
// RV32I instruction encoder: turns a decoded request into a 32-bit word,
// expanding the LI pseudo-instruction into LUI+ADDI when needed.
module inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_kind,
  input  logic [4:0]  req_aluop,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic        enc_err
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, HOLD_LI = 2'd2} state_t;

  state_t      state;
  logic [31:0] pend;
  logic        accept;
  logic        take;
  logic [2:0]  f3_alu;
  logic [6:0]  f7_alu;
  logic        alu_ok;
  logic        is_shift;
  logic        fit_i;
  logic        fit_b;
  logic        fit_j;
  logic        fit_sh;
  logic [19:0] li_hi;
  logic        legal;
  logic        two;
  logic [31:0] w0;
  logic [31:0] w1;

  assign accept = req_valid & req_ready;
  assign take   = inst_valid & inst_ready;

  always_comb begin
    case (state)
      IDLE:    req_ready = 1'b1;
      HOLD:    req_ready = inst_ready;
      HOLD_LI: req_ready = 1'b0;
      default: req_ready = 1'b0;
    endcase
  end

  // Range checks are sign-extension tests on the upper immediate bits.
  always_comb begin
    case (req_aluop)
      5'd0, 5'd1: f3_alu = 3'b000;
      5'd2:       f3_alu = 3'b001;
      5'd3:       f3_alu = 3'b010;
      5'd4:       f3_alu = 3'b011;
      5'd5:       f3_alu = 3'b100;
      5'd6, 5'd7: f3_alu = 3'b101;
      5'd8:       f3_alu = 3'b110;
      5'd9:       f3_alu = 3'b111;
      default:    f3_alu = 3'b000;
    endcase
    f7_alu   = ((req_aluop == 5'd1) || (req_aluop == 5'd7)) ? 7'b0100000 : 7'b0000000;
    alu_ok   = (req_aluop <= 5'd9);
    is_shift = (req_aluop == 5'd2) || (req_aluop == 5'd6) || (req_aluop == 5'd7);
    fit_i    = (&req_imm[31:11]) | ~(|req_imm[31:11]);
    fit_b    = ((&req_imm[31:12]) | ~(|req_imm[31:12])) & ~req_imm[0];
    fit_j    = ((&req_imm[31:20]) | ~(|req_imm[31:20])) & ~req_imm[0];
    fit_sh   = ~(|req_imm[31:5]);
    // Rounding the upper part compensates for the sign-extended ADDI low part.
    li_hi    = req_imm[31:12] + {19'd0, req_imm[11]};
    legal    = 1'b0;
    two      = 1'b0;
    w0       = 32'd0;
    w1       = {req_imm[11:0], req_rd, 3'b000, req_rd, OP_I};
    case (req_kind)
      4'd0: begin
        legal = alu_ok;
        w0    = {f7_alu, req_rs2, req_rs1, f3_alu, req_rd, OP_R};
      end
      4'd1: begin
        if (is_shift) begin
          legal = fit_sh;
          w0    = {f7_alu, req_imm[4:0], req_rs1, f3_alu, req_rd, OP_I};
        end else begin
          legal = alu_ok & (req_aluop != 5'd1) & fit_i;
          w0    = {req_imm[11:0], req_rs1, f3_alu, req_rd, OP_I};
        end
      end
      4'd2: begin
        legal = fit_i;
        w0    = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD};
      end
      4'd3: begin
        legal = fit_i;
        w0    = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OP_STORE};
      end
      4'd4: begin
        legal = 1'b1;
        w0    = {req_imm[19:0], req_rd, OP_LUI};
      end
      4'd5: begin
        legal = 1'b1;
        w0    = {req_imm[19:0], req_rd, OP_AUIPC};
      end
      4'd6: begin
        legal = fit_b;
        w0    = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                 req_imm[4:1], req_imm[11], OP_BRANCH};
      end
      4'd7: begin
        legal = fit_j;
        w0    = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
      end
      4'd8: begin
        legal = fit_i;
        w0    = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
      end
      4'd9: begin
        legal = 1'b1;
        if (fit_i) begin
          w0 = {req_imm[11:0], 5'd0, 3'b000, req_rd, OP_I};
        end else begin
          two = |req_imm[11:0];
          w0  = {li_hi, req_rd, OP_LUI};
        end
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Illegal requests only raise enc_err; the held word still drains normally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      inst_valid <= 1'b0;
      inst_data  <= 32'd0;
      pend       <= 32'd0;
      enc_err    <= 1'b0;
    end else begin
      enc_err <= accept & ~legal;
      case (state)
        IDLE: begin
          if (accept && legal) begin
            inst_data  <= w0;
            inst_valid <= 1'b1;
            pend       <= w1;
            state      <= two ? HOLD_LI : HOLD;
          end
        end
        HOLD: begin
          if (take) begin
            if (accept && legal) begin
              inst_data <= w0;
              pend      <= w1;
              state     <= two ? HOLD_LI : HOLD;
            end else begin
              inst_valid <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        HOLD_LI: begin
          if (take) begin
            inst_data <= pend;
            state     <= HOLD;
          end
        end
        default: begin
          inst_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed plus randomized bench for inst_encoder; expected words come from an
// arithmetic reference model and a queue of words still owed by the DUT.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_kind = 4'd0;
  logic [4:0]  req_aluop = 5'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [4:0]  req_rs1 = 5'd0;
  logic [4:0]  req_rs2 = 5'd0;
  logic [31:0] req_imm = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic        enc_err;

  int          ntests = 0;
  int          nfail = 0;
  logic [31:0] q[$];
  logic        exp_err = 1'b0;
  int          f3t[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int          edges[18] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4097,
                             1048574, -1048576, 1048576, 31, 32, 0,
                             32'h7FFFF800, 32'h7FFFFFFF, 32'h00001000};

  inst_encoder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_aluop(req_aluop), .req_funct3(req_funct3),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .enc_err(enc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_enc(input int kind, input int op, input int f3, input int rd,
                                  input int rs1, input int rs2, input int imm,
                                  output bit ok, output bit two,
                                  output logic [31:0] w0, output logic [31:0] w1);
    int  fa = (op <= 9) ? f3t[op] : 0;
    int  f7 = (op == 1 || op == 7) ? 32 : 0;
    bit  sh = (op == 2 || op == 6 || op == 7);
    bit  fi = (imm >= -2048 && imm <= 2047);
    int  hi;
    int  lo;
    ok = 1'b0; two = 1'b0; w0 = 32'd0; w1 = 32'd0;
    case (kind)
      0: begin ok = (op <= 9); w0 = f7 << 25 | rs2 << 20 | rs1 << 15 | fa << 12 | rd << 7 | 'h33; end
      1: begin
        if (sh) begin
          ok = (imm >= 0 && imm <= 31);
          w0 = f7 << 25 | (imm & 31) << 20 | rs1 << 15 | fa << 12 | rd << 7 | 'h13;
        end else begin
          ok = (op <= 9) && (op != 1) && fi;
          w0 = (imm & 'hFFF) << 20 | rs1 << 15 | fa << 12 | rd << 7 | 'h13;
        end
      end
      2: begin ok = fi; w0 = (imm & 'hFFF) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | 'h03; end
      3: begin
        ok = fi;
        w0 = ((imm >> 5) & 'h7F) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12 | (imm & 31) << 7 | 'h23;
      end
      4: begin ok = 1'b1; w0 = (imm & 'hFFFFF) << 12 | rd << 7 | 'h37; end
      5: begin ok = 1'b1; w0 = (imm & 'hFFFFF) << 12 | rd << 7 | 'h17; end
      6: begin
        ok = (imm >= -4096 && imm <= 4094 && imm % 2 == 0);
        w0 = ((imm >> 12) & 1) << 31 | ((imm >> 5) & 63) << 25 | rs2 << 20 | rs1 << 15 |
             f3 << 12 | ((imm >> 1) & 15) << 8 | ((imm >> 11) & 1) << 7 | 'h63;
      end
      7: begin
        ok = (imm >= -1048576 && imm <= 1048574 && imm % 2 == 0);
        w0 = ((imm >> 20) & 1) << 31 | ((imm >> 1) & 'h3FF) << 21 | ((imm >> 11) & 1) << 20 |
             ((imm >> 12) & 'hFF) << 12 | rd << 7 | 'h6F;
      end
      8: begin ok = fi; w0 = (imm & 'hFFF) << 20 | rs1 << 15 | rd << 7 | 'h67; end
      9: begin
        ok = 1'b1;
        if (fi) begin
          w0 = (imm & 'hFFF) << 20 | rd << 7 | 'h13;
        end else begin
          hi  = ((imm + 'h800) >>> 12) & 'hFFFFF;
          lo  = imm & 'hFFF;
          w0  = hi << 12 | rd << 7 | 'h37;
          two = (lo != 0);
          w1  = lo << 20 | rd << 15 | rd << 7 | 'h13;
        end
      end
      default: ok = 1'b0;
    endcase
  endfunction

  // One clock: drive, check against the model, then advance the model.
  task automatic cyc(input logic v, input int kind, input int op, input int f3, input int rd,
                     input int rs1, input int rs2, input int imm, input logic ir);
    bit          ok, two, er, acc;
    logic [31:0] w0, w1;
    @(negedge clk);
    req_valid = v; req_kind = kind[3:0]; req_aluop = op[4:0]; req_funct3 = f3[2:0];
    req_rd = rd[4:0]; req_rs1 = rs1[4:0]; req_rs2 = rs2[4:0]; req_imm = imm; inst_ready = ir;
    #1;
    er = (q.size() == 0) || (q.size() == 1 && ir);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) chk("inst_data", inst_data, q[0]);
    chk("req_ready", {31'd0, req_ready}, {31'd0, er});
    chk("enc_err", {31'd0, enc_err}, {31'd0, exp_err});
    acc = v && er;
    if (q.size() != 0 && ir) void'(q.pop_front());
    exp_err = 1'b0;
    if (acc) begin
      ref_enc(kind, op, f3, rd, rs1, rs2, imm, ok, two, w0, w1);
      if (ok) begin
        q.push_back(w0);
        if (two) q.push_back(w1);
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic ir);
    cyc(1'b0, 0, 0, 0, 0, 0, 0, 0, ir);
  endtask

  function automatic int rand_imm();
    case ($urandom_range(0, 4))
      0: return int'($urandom_range(0, 4095)) - 2048;
      1: return int'($urandom);
      2: return edges[$urandom_range(0, 17)];
      3: return int'($urandom_range(0, 63)) - 16;
      default: return int'($urandom_range(0, 2097152)) - 1048576;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_err", {31'd0, enc_err}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    cyc(1'b1, 0, 0, 0, 3, 1, 2, 0, 1'b1);
    idle(1'b1);
    chk("r_add", inst_data, 32'h002081B3);

    cyc(1'b1, 9, 0, 0, 5, 0, 0, 32'h12345678, 1'b1);
    idle(1'b1);
    chk("li_lui", inst_data, 32'h123452B7);
    chk("li_hold_ready", {31'd0, req_ready}, 32'd0);
    idle(1'b1);
    chk("li_addi", inst_data, 32'h67828293);
    idle(1'b1);

    cyc(1'b1, 9, 0, 0, 1, 0, 0, -1, 1'b1);
    idle(1'b0);
    chk("li_m1", inst_data, 32'hFFF00093);
    cyc(1'b1, 9, 0, 0, 6, 0, 0, 32'h00001000, 1'b1);
    idle(1'b1);
    chk("li_4k", inst_data, 32'h00001337);
    idle(1'b1);
    chk("li_4k_single", {31'd0, inst_valid}, 32'd0);

    cyc(1'b1, 1, 1, 0, 4, 4, 0, 5, 1'b1);
    idle(1'b1);
    chk("isub_err", {31'd0, enc_err}, 32'd1);
    cyc(1'b1, 6, 0, 0, 0, 1, 2, 3, 1'b1);
    idle(1'b1);
    chk("br_odd_err", {31'd0, enc_err}, 32'd1);
    chk("br_odd_novalid", {31'd0, inst_valid}, 32'd0);

    cyc(1'b1, 7, 0, 0, 1, 0, 0, -1048576, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    chk("stall_ready", {31'd0, req_ready}, 32'd0);
    chk("stall_data", inst_data, 32'h8000_00EF);
    idle(1'b1);
    idle(1'b1);

    cyc(1'b1, 9, 0, 0, 5, 0, 0, 32'h12345678, 1'b0);
    idle(1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'd0, inst_valid}, 32'd0);
    q.delete();
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) idle(1'b1);

    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 11), $urandom_range(0, 11),
          $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 31), rand_imm(), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
